stp_frame_ctrl: RTL and testbench
=================================

STP_FRAME_CTRL -- requirements
Module: stp_frame_ctrl

Interface
REQ-001: Parameter SYNC_PATTERN, default 4'b1101, is the 4-bit sync word that marks the start of a frame.
REQ-002: Parameter PAYLOAD_BITS, default 8, is the number of payload bits per frame; the legal range is 2..16.
REQ-003: clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004: n_rst  input  1  is an asynchronous, active-low reset.
REQ-005: ser_in  input  1  is the serial data bit, MSB-first.
REQ-006: shift_en  input  1  is the sample strobe; ser_in is sampled only on edges where shift_en=1.
REQ-007: abort  input  1  is a synchronous abandon of the current frame.
REQ-008: data_ready  input  1  is the consumer acceptance of data_out.
REQ-009: clr_err  input  1  is a synchronous clear of overrun.
REQ-010: data_out  output  PAYLOAD_BITS  is the last completed payload (registered).
REQ-011: data_valid  output  1  is high while data_out holds an unconsumed frame.
REQ-012: sync_found  output  1  is a one-cycle pulse on sync detection.
REQ-013: busy  output  1  is high while in state LOAD.
REQ-014: overrun  output  1  is a sticky flag: a frame completed while the previous one was unconsumed.

Function
REQ-015: The FSM SHALL have exactly two states: HUNT and LOAD; all outputs are registered.
REQ-016: In HUNT, on shift_en=1: window <= {window[2:0], ser_in}; fill <= min(fill+1, 4).
REQ-017: In HUNT, sync is detected when the post-shift window equals SYNC_PATTERN and the post-shift fill equals 4; bits received before HUNT entry never count toward a match.
REQ-018: On sync detection, the FSM SHALL go to LOAD next cycle, pulse sync_found=1 for exactly that one cycle, and clear bit_cnt to 0 and the payload register to 0.
REQ-019: In LOAD, on shift_en=1: payload <= {payload[PAYLOAD_BITS-2:0], ser_in}; bit_cnt <= bit_cnt+1.
REQ-020: The shift that makes bit_cnt reach PAYLOAD_BITS SHALL complete the frame; the completed value (including that bit) is presented next cycle, and the FSM returns to HUNT with window=0 and fill=0.
REQ-021: bit_cnt SHALL be $clog2(PAYLOAD_BITS+1) bits wide and never exceed PAYLOAD_BITS.
REQ-022: Frame completion with data_valid=0 SHALL load data_out and set data_valid=1 on the same edge.
REQ-023: When data_valid=1 and data_ready=1 at an edge, the frame is consumed and data_valid SHALL clear on that edge.
REQ-024: If consumption and completion occur on the same edge, data_out SHALL load the new frame and data_valid SHALL stay 1; overrun is not set.
REQ-025: Completion while data_valid=1 and data_ready=0 SHALL keep the old data_out, discard the new frame, and set overrun=1.
REQ-026: data_out SHALL remain stable while data_valid=1 and the frame is not consumed.
REQ-027: overrun SHALL clear when clr_err=1; if clr_err coincides with a new overrun event, set wins.
REQ-028: abort=1 SHALL force HUNT next cycle from either state, clearing window, fill, bit_cnt and payload, and suppressing any sync detection or completion on that edge.
REQ-029: abort SHALL NOT affect data_out, data_valid or overrun.
REQ-030: shift_en=0 SHALL freeze window, fill, bit_cnt and payload; the handshake and clr_err still operate.
REQ-031: busy SHALL equal 1 exactly when the state is LOAD.

Reset
REQ-032: While n_rst=0, the block SHALL asynchronously force: state HUNT; window 0; fill 0; bit_cnt 0; payload 0; data_out 0; data_valid 0; sync_found 0; busy 0; overrun 0.
REQ-033: Reset asserted mid-LOAD SHALL discard the partial frame; after release the block hunts afresh and requires 4 new bits before any match.

Verification
REQ-034: Reset, then shift 1,1,0,1 then 1,0,1,0,0,1,0,1 with shift_en=1 every cycle and data_ready=0 -> sync_found pulses after the 4th shift edge, busy=1 for the next 8 shifts, then data_out=8'hA5 and data_valid=1.
REQ-035: Stream 0,1,1,0,1 -> a match occurs only on the 5th bit; leading zeros from reset never produce a match against SYNC_PATTERN=4'b0xxx-style windows.
REQ-036: Complete two frames (0xA5 then 0x3C) with data_ready=0 -> data_out stays 0xA5 and overrun=1; clr_err=1 -> overrun=0.
REQ-037: Hold data_ready=1 on the completion edge of the second frame -> data_out=0x3C, data_valid stays 1, overrun=0.
REQ-038: abort asserted after 4 payload bits -> HUNT next cycle and busy=0; a subsequent full frame of 0xFF yields 0xFF.
REQ-039: n_rst pulsed low mid-LOAD with shift_en toggling randomly -> all outputs 0 immediately; the next clean sync and frame of 0x5A yields data_out=0x5A.

Source files
------------

// File: rtl/stp_frame_ctrl.sv
// rtl/stp_frame_ctrl.sv - serial sync-hunting frame receiver with consumer handshake
module stp_frame_ctrl #(
    parameter logic [3:0] SYNC_PATTERN = 4'b1101,
    parameter int         PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    ser_in,
    input  logic                    shift_en,
    input  logic                    abort,
    input  logic                    data_ready,
    input  logic                    clr_err,
    output logic [PAYLOAD_BITS-1:0] data_out,
    output logic                    data_valid,
    output logic                    sync_found,
    output logic                    busy,
    output logic                    overrun
);

    localparam int              CW       = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(PAYLOAD_BITS);

    typedef enum logic {
        HUNT = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_window;
    logic [2:0]              r_fill;
    logic [CW-1:0]           r_bit_cnt;
    logic [PAYLOAD_BITS-1:0] r_payload;
    logic [PAYLOAD_BITS-1:0] r_data_out;
    logic                    r_data_valid;
    logic                    r_sync_found;
    logic                    r_overrun;

    state_t                  w_state;
    logic [3:0]              w_window;
    logic [2:0]              w_fill;
    logic [CW-1:0]           w_bit_cnt;
    logic [PAYLOAD_BITS-1:0] w_payload;
    logic [PAYLOAD_BITS-1:0] w_data_out;
    logic                    w_data_valid;
    logic                    w_sync_found;
    logic                    w_overrun;

    logic [3:0]              w_win_shift;
    logic [2:0]              w_fill_inc;
    logic [PAYLOAD_BITS-1:0] w_pay_shift;
    logic [CW-1:0]           w_cnt_inc;
    logic                    w_complete;

    // Next-state and next-output decode: hunt for the sync word, collect payload, run the handshake
    always_comb begin
        w_state      = r_state;
        w_window     = r_window;
        w_fill       = r_fill;
        w_bit_cnt    = r_bit_cnt;
        w_payload    = r_payload;
        w_data_out   = r_data_out;
        w_data_valid = r_data_valid;
        w_overrun    = r_overrun;
        w_sync_found = 1'b0;
        w_complete   = 1'b0;

        w_win_shift  = {r_window[2:0], ser_in};
        w_fill_inc   = (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
        w_pay_shift  = {r_payload[PAYLOAD_BITS-2:0], ser_in};
        w_cnt_inc    = r_bit_cnt + CW'(1);

        if (abort) begin
            // Abandon wins over any detection or completion on this edge
            w_state   = HUNT;
            w_window  = 4'd0;
            w_fill    = 3'd0;
            w_bit_cnt = '0;
            w_payload = '0;
        end else if (shift_en) begin
            case (r_state)
                HUNT: begin
                    w_window = w_win_shift;
                    w_fill   = w_fill_inc;
                    if ((w_win_shift == SYNC_PATTERN) && (w_fill_inc == 3'd4)) begin
                        w_sync_found = 1'b1;
                        w_state      = LOAD;
                        w_bit_cnt    = '0;
                        w_payload    = '0;
                        w_window     = 4'd0;
                        w_fill       = 3'd0;
                    end
                end
                LOAD: begin
                    w_payload = w_pay_shift;
                    w_bit_cnt = w_cnt_inc;
                    if (w_cnt_inc == LAST_CNT) begin
                        // Fill restarts at zero so the next sync needs four fresh bits
                        w_complete = 1'b1;
                        w_state    = HUNT;
                        w_window   = 4'd0;
                        w_fill     = 3'd0;
                        w_bit_cnt  = '0;
                    end
                end
                default: w_state = HUNT;
            endcase
        end

        // A completed frame is only accepted if the output slot is free or freed on this edge
        if (w_complete && (!r_data_valid || data_ready)) begin
            w_data_out   = w_pay_shift;
            w_data_valid = 1'b1;
        end else if (r_data_valid && data_ready) begin
            w_data_valid = 1'b0;
        end

        // Overrun set has priority over the clear request
        if (w_complete && r_data_valid && !data_ready) begin
            w_overrun = 1'b1;
        end else if (clr_err) begin
            w_overrun = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= HUNT;
            r_window     <= 4'd0;
            r_fill       <= 3'd0;
            r_bit_cnt    <= '0;
            r_payload    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sync_found <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_window     <= w_window;
            r_fill       <= w_fill;
            r_bit_cnt    <= w_bit_cnt;
            r_payload    <= w_payload;
            r_data_out   <= w_data_out;
            r_data_valid <= w_data_valid;
            r_sync_found <= w_sync_found;
            r_overrun    <= w_overrun;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sync_found = r_sync_found;
    assign busy       = (r_state == LOAD);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_stp_frame_ctrl.sv
// tb/tb_stp_frame_ctrl.sv - scoreboard bench for stp_frame_ctrl against a bit-queue reference model
module tb_stp_frame_ctrl;

    localparam int         PB   = 8;
    localparam logic [3:0] SYNC = 4'b1101;

    logic          clk        = 1'b0;
    logic          n_rst      = 1'b1;
    logic          ser_in     = 1'b0;
    logic          shift_en   = 1'b0;
    logic          abort      = 1'b0;
    logic          data_ready = 1'b0;
    logic          clr_err    = 1'b0;
    logic [PB-1:0] data_out;
    logic          data_valid;
    logic          sync_found;
    logic          busy;
    logic          overrun;

    stp_frame_ctrl #(
        .SYNC_PATTERN (SYNC),
        .PAYLOAD_BITS (PB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ser_in     (ser_in),
        .shift_en   (shift_en),
        .abort      (abort),
        .data_ready (data_ready),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_found (sync_found),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bits since hunt entry, payload bits collected, output slot
    bit            m_hunting = 1'b1;
    int            m_bits[$];
    int            m_pay[$];
    logic [PB-1:0] m_out = '0;
    bit            m_dv  = 1'b0;
    bit            m_ov  = 1'b0;

    logic [PB-1:0] q_frames[$];
    int            q_sync[$];
    bit            mon_en  = 1'b0;
    bit            prev_dv = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks = n_checks + 1;
        if (ok) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_bits.delete();
        m_pay.delete();
        m_out = '0;
        m_dv  = 1'b0;
        m_ov  = 1'b0;
        q_sync.delete();
        q_frames.delete();
    endtask

    task automatic model_edge(input bit s, input bit en, input bit ab, input bit rdy, input bit clr);
        bit complete;
        int frame;
        int w;
        complete = 1'b0;
        frame    = 0;
        if (ab) begin
            m_hunting = 1'b1;
            m_bits.delete();
            m_pay.delete();
        end else if (en) begin
            if (m_hunting) begin
                m_bits.push_back(int'(s));
                if (m_bits.size() > 4) void'(m_bits.pop_front());
                if (m_bits.size() == 4) begin
                    w = m_bits[0] * 8 + m_bits[1] * 4 + m_bits[2] * 2 + m_bits[3];
                    if (w == int'(SYNC)) begin
                        m_hunting = 1'b0;
                        m_bits.delete();
                        m_pay.delete();
                        q_sync.push_back(cyc + 1);
                    end
                end
            end else begin
                m_pay.push_back(int'(s));
                if (m_pay.size() == PB) begin
                    complete = 1'b1;
                    foreach (m_pay[i]) frame = frame * 2 + m_pay[i];
                    m_pay.delete();
                    m_hunting = 1'b1;
                end
            end
        end
        if (complete && m_dv && !rdy) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        if (complete && (!m_dv || rdy)) begin
            m_out = PB'(frame);
            m_dv  = 1'b1;
            q_frames.push_back(PB'(frame));
        end else if (m_dv && rdy) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic step(input bit s, input bit en, input bit ab, input bit rdy, input bit clr);
        @(negedge clk);
        ser_in = s; shift_en = en; abort = ab; data_ready = rdy; clr_err = clr;
        model_edge(s, en, ab, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [15:0] v, input int n, input bit rdy);
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset(input bit noisy);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check({data_out, data_valid, sync_found, busy, overrun} == '0, "reset_outputs",
              {data_out, data_valid, sync_found, busy, overrun}, 0);
        repeat (3) begin
            @(negedge clk);
            ser_in = 1'($urandom); shift_en = noisy ? 1'($urandom) : 1'b0;
            abort = 1'b0; data_ready = 1'($urandom); clr_err = 1'b0;
        end
        @(negedge clk);
        ser_in = 1'b0; shift_en = 1'b0; abort = 1'b0; data_ready = 1'b0; clr_err = 1'b0;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected frames on each presentation, tracks sync pulses and visible state
    initial begin
        logic [PB-1:0] exp_frame;
        bit            exp_sync;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #2;
            if (data_valid && (!prev_dv || data_ready)) begin
                check(q_frames.size() > 0, "frame_queue", q_frames.size(), 1);
                if (q_frames.size() > 0) begin
                    exp_frame = q_frames.pop_front();
                    check(data_out == exp_frame, "frame_value", data_out, exp_frame);
                end
            end
            exp_sync = (q_sync.size() > 0) && (q_sync[0] == cyc);
            if (exp_sync) void'(q_sync.pop_front());
            check(sync_found == exp_sync, "sync_found", sync_found, exp_sync);
            check({busy, data_valid, overrun, data_out} == {!m_hunting, m_dv, m_ov, m_out}, "state",
                  {busy, data_valid, overrun, data_out}, {!m_hunting, m_dv, m_ov, m_out});
            prev_dv = data_valid;
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        do_reset(1'b0);
        mon_en = 1'b1;

        // Basic frame 0xA5 with consumer stalled
        shift_word(16'(SYNC), 4, 1'b0);
        check(sync_found == 1'b1, "sync_after_4th", sync_found, 1);
        check(busy == 1'b1, "busy_after_sync", busy, 1);
        for (int i = 7; i >= 0; i--) begin
            step(1'(8'hA5 >> i), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i > 0) check(busy == 1'b1, "busy_in_load", busy, 1);
        end
        check(data_out == 8'hA5, "a5_data", data_out, 8'hA5);
        check(data_valid == 1'b1, "a5_valid", data_valid, 1);
        check(busy == 1'b0, "a5_busy_off", busy, 0);

        // Second frame while stalled -> overrun, old data kept
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'h3C, 8, 1'b0);
        check(data_out == 8'hA5, "ovr_keep_data", data_out, 8'hA5);
        check(overrun == 1'b1, "ovr_set", overrun, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check(overrun == 1'b0, "ovr_clear", overrun, 0);
        check(data_valid == 1'b1, "ovr_valid_held", data_valid, 1);

        // Consume on the completion edge -> new frame loaded, no overrun
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'h1E, 7, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check(data_out == 8'h3C, "swap_data", data_out, 8'h3C);
        check(data_valid == 1'b1, "swap_valid", data_valid, 1);
        check(overrun == 1'b0, "swap_no_ovr", overrun, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check(data_valid == 1'b0, "consume_clear", data_valid, 0);

        // Abort mid-payload, then a clean 0xFF frame
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'hA, 4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check(busy == 1'b0, "abort_busy", busy, 0);
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'hFF, 8, 1'b0);
        check(data_out == 8'hFF, "ff_data", data_out, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Match only on the fifth bit of 0,1,1,0,1 after reset
        do_reset(1'b0);
        shift_word(16'h6, 4, 1'b0);
        check(sync_found == 1'b0, "no_sync_4th", sync_found, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check(sync_found == 1'b1, "sync_5th", sync_found, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset pulse mid-load with noisy shift strobe, then 0x5A
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'h5, 3, 1'b0);
        do_reset(1'b1);
        shift_word(16'(SYNC), 4, 1'b0);
        shift_word(16'h5A, 8, 1'b0);
        check(data_out == 8'h5A, "5a_data", data_out, 8'h5A);
        check(data_valid == 1'b1, "5a_valid", data_valid, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 5);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(q_frames.size() == 0, "frames_pending", q_frames.size(), 0);
        check(q_sync.size() == 0, "sync_pending", q_sync.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
